// File: rtl/bit_window_feeder_16to32_seq.sv
// Packs 16-bit words into a 32-bit sliding window and tracks the LSB-first bit pointer
// that the downstream 32x16 bit-selection stage uses as its extraction offset.
module bit_window_feeder_16to32_seq #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned IN_WIDTH      = DATA_WIDTH >> 1,
   parameter int unsigned COMMAND_WIDTH = $clog2(DATA_WIDTH) - 1,
   parameter int unsigned LEN_WIDTH     = COMMAND_WIDTH + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_valid,
   output logic                     i_ready,
   input  logic [IN_WIDTH-1:0]      i_data,
   input  logic                     i_flush,
   output logic                     o_valid,
   input  logic                     o_ready,
   output logic [DATA_WIDTH-1:0]    o_data_bus,
   output logic [COMMAND_WIDTH-1:0] o_cmd,
   input  logic [LEN_WIDTH-1:0]     i_len
);

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StHalf  = 2'd1,
      StFull  = 2'd2
   } cnt_e;

   localparam logic [LEN_WIDTH-1:0] MaxLen = LEN_WIDTH'(IN_WIDTH);

   cnt_e                     cnt_q, cnt_d;
   logic [COMMAND_WIDTH-1:0] ptr_q, ptr_d;
   logic [IN_WIDTH-1:0]      w_lo_q, w_lo_d;
   logic [IN_WIDTH-1:0]      w_hi_q, w_hi_d;

   logic [LEN_WIDTH-1:0] len_clamped;
   logic [LEN_WIDTH-1:0] sum;
   logic                 in_fire;
   logic                 out_fire;
   logic                 pop;

   // Outputs come straight from state; only i_ready sees the downstream handshake.
   assign o_valid    = (cnt_q == StFull);
   assign o_data_bus = {w_hi_q, w_lo_q};
   assign o_cmd      = ptr_q;

   assign len_clamped = (i_len > MaxLen) ? MaxLen : i_len;
   assign sum         = {1'b0, ptr_q} + len_clamped;
   assign out_fire    = o_valid & o_ready;
   // Crossing the word boundary retires w_lo and frees a slot in the same cycle.
   assign pop         = out_fire & sum[LEN_WIDTH-1];
   assign i_ready     = (cnt_q != StFull) | pop;
   assign in_fire     = i_valid & i_ready;

   always_comb begin
      cnt_d  = cnt_q;
      ptr_d  = ptr_q;
      w_lo_d = w_lo_q;
      w_hi_d = w_hi_q;

      if (i_flush) begin
         cnt_d  = StEmpty;
         ptr_d  = '0;
         w_lo_d = '0;
         w_hi_d = '0;
      end else begin
         // sum-16 and sum share their low bits, so one slice covers both cases.
         if (out_fire) begin
            ptr_d = sum[COMMAND_WIDTH-1:0];
         end

         unique case (cnt_q)
            StEmpty: begin
               if (in_fire) begin
                  w_lo_d = i_data;
                  cnt_d  = StHalf;
               end
            end
            StHalf: begin
               if (in_fire) begin
                  w_hi_d = i_data;
                  cnt_d  = StFull;
               end
            end
            StFull: begin
               if (pop) begin
                  w_lo_d = w_hi_q;
                  if (in_fire) begin
                     w_hi_d = i_data;
                  end else begin
                     cnt_d = StHalf;
                  end
               end
            end
            default: begin
               cnt_d = StEmpty;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= StEmpty;
         ptr_q  <= '0;
         w_lo_q <= '0;
         w_hi_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         ptr_q  <= ptr_d;
         w_lo_q <= w_lo_d;
         w_hi_q <= w_hi_d;
      end
   end

endmodule

// File: tb/tb_bit_window_feeder_16to32_seq.sv
// Directed bench for bit_window_feeder_16to32_seq: reset, fill, strides, edge lengths, flush.
module tb_bit_window_feeder_16to32_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid;
   logic        i_ready;
   logic [15:0] i_data;
   logic        i_flush;
   logic        o_valid;
   logic        o_ready;
   logic [31:0] o_data_bus;
   logic [3:0]  o_cmd;
   logic [4:0]  i_len;

   int n_checks = 0;
   int n_fail   = 0;

   bit_window_feeder_16to32_seq dut (
      .clk        (clk),
      .rst        (rst),
      .i_valid    (i_valid),
      .i_ready    (i_ready),
      .i_data     (i_data),
      .i_flush    (i_flush),
      .o_valid    (o_valid),
      .o_ready    (o_ready),
      .o_data_bus (o_data_bus),
      .o_cmd      (o_cmd),
      .i_len      (i_len)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic v, input logic [31:0] bus,
                            input logic [3:0] cmd);
      check_eq({tag, ".o_valid"}, 32'(o_valid), 32'(v));
      check_eq({tag, ".o_data_bus"}, o_data_bus, bus);
      check_eq({tag, ".o_cmd"}, 32'(o_cmd), 32'(cmd));
   endtask

   task automatic push(input logic [15:0] d);
      i_valid = 1'b1;
      i_data  = d;
      tick();
      i_valid = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      i_valid = 1'b1;
      i_data  = 16'hFFFF;
      i_flush = 1'b0;
      o_ready = 1'b0;
      i_len   = 5'd0;

      // 1: reset holds outputs cleared while input is offered
      #1;
      for (int i = 0; i < 2; i++) begin
         check_out("rst", 1'b0, 32'h0, 4'd0);
         check_eq("rst.i_ready", 32'(i_ready), 32'd1);
         tick();
      end
      rst     = 1'b0;
      i_valid = 1'b0;
      tick();
      check_out("rst_rel", 1'b0, 32'h0, 4'd0);
      check_eq("rst_rel.i_ready", 32'(i_ready), 32'd1);

      // 2: fill two words with downstream stalled
      push(16'h0810);
      check_eq("fill1.o_valid", 32'(o_valid), 32'd0);
      push(16'hA442);
      i_valid = 1'b1;
      i_data  = 16'hDEAD;
      for (int i = 0; i < 5; i++) begin
         #1;
         check_out("fill_hold", 1'b1, 32'hA4420810, 4'd0);
         check_eq("fill_hold.i_ready", 32'(i_ready), 32'd0);
         tick();
      end

      // 3: stride 4, pop+push on the fourth accept
      i_data  = 16'h1234;
      o_ready = 1'b1;
      i_len   = 5'd4;
      #1;
      check_eq("stride0.i_ready", 32'(i_ready), 32'd0);
      check_eq("stride0.o_cmd", 32'(o_cmd), 32'd0);
      tick();
      check_eq("stride1.o_cmd", 32'(o_cmd), 32'd4);
      tick();
      check_eq("stride2.o_cmd", 32'(o_cmd), 32'd8);
      tick();
      check_eq("stride3.o_cmd", 32'(o_cmd), 32'd12);
      check_eq("stride3.i_ready", 32'(i_ready), 32'd1);
      tick();
      i_valid = 1'b0;
      check_out("stride_pop", 1'b1, 32'h1234A442, 4'd0);

      // 4: odd stride 9, second accept wraps to 2 with no word pending
      i_len = 5'd9;
      tick();
      check_out("odd1", 1'b1, 32'h1234A442, 4'd9);
      tick();
      o_ready = 1'b0;
      check_eq("odd2.o_valid", 32'(o_valid), 32'd0);
      check_eq("odd2.o_cmd", 32'(o_cmd), 32'd2);
      check_eq("odd2.w_lo", 32'(o_data_bus[15:0]), 32'h1234);
      check_eq("odd2.i_ready", 32'(i_ready), 32'd1);

      // 5: edge lengths
      push(16'h5678);
      check_out("refill", 1'b1, 32'h56781234, 4'd2);
      o_ready = 1'b1;
      i_len   = 5'd0;
      tick();
      check_out("len0", 1'b1, 32'h56781234, 4'd2);
      i_len = 5'd1;
      tick();
      check_eq("len1.o_cmd", 32'(o_cmd), 32'd3);
      i_len = 5'd31;
      #1;
      check_eq("len31.i_ready", 32'(i_ready), 32'd1);
      tick();
      o_ready = 1'b0;
      check_eq("len31.o_valid", 32'(o_valid), 32'd0);
      check_eq("len31.o_cmd", 32'(o_cmd), 32'd3);
      check_eq("len31.w_lo", 32'(o_data_bus[15:0]), 32'h5678);

      // 6a: flush while full with a concurrent push and accept
      push(16'h9ABC);
      check_out("pre_flush", 1'b1, 32'h9ABC5678, 4'd3);
      o_ready = 1'b1;
      i_len   = 5'd16;
      i_valid = 1'b1;
      i_data  = 16'h1111;
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      i_valid = 1'b0;
      o_ready = 1'b0;
      check_out("flush", 1'b0, 32'h0, 4'd0);
      check_eq("flush.i_ready", 32'(i_ready), 32'd1);
      push(16'h2222);
      push(16'h3333);
      check_out("post_flush", 1'b1, 32'h33332222, 4'd0);

      // 6b: asynchronous reset mid-operation
      o_ready = 1'b1;
      i_len   = 5'd5;
      i_valid = 1'b1;
      i_data  = 16'h4444;
      rst     = 1'b1;
      #1;
      check_out("rst_mid", 1'b0, 32'h0, 4'd0);
      tick();
      rst     = 1'b0;
      i_valid = 1'b0;
      o_ready = 1'b0;
      tick();
      check_out("rst_mid_rel", 1'b0, 32'h0, 4'd0);
      push(16'h5555);
      push(16'h6666);
      check_out("post_rst", 1'b1, 32'h66665555, 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
